// File: rtl/aum_trit_alu_if.sv
// rtl/aum_trit_alu_if.sv - request/result bundle between AUM operand registers, ALU and result bus
// master drives requests and consumes results; slave is the ALU.
interface aum_trit_alu_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         op;
  logic [2*WIDTH-1:0] a;
  logic [2*WIDTH-1:0] b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] y;
  logic [1:0]         carry;
  logic               busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, carry, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, carry, busy
  );
endinterface

// File: rtl/aum_trit_alu.sv
// rtl/aum_trit_alu.sv - WIDTH-trit AUM vector ALU: trit-wise logic ops and serial balanced-ternary ADD
// Trits are M=00, U=01, A=10 after normalisation, so unsigned compare gives the M<U<A order.
module aum_trit_alu #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  aum_trit_alu_if.slave bus
);
  localparam int VW = 2 * WIDTH;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] T_M = 2'b00;
  localparam logic [1:0] T_U = 2'b01;
  localparam logic [1:0] T_A = 2'b10;
  localparam logic [2:0] OP_ADD = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   a_q, a_d, b_q, b_d, y_q, y_d;
  logic [1:0]      carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [VW-1:0]   a_n, b_n;
  logic [3:0]      step;
  logic            in_ready, accept;

  function automatic logic [VW-1:0] norm_vec(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[2*i +: 2] == 2'b11) r[2*i +: 2] = T_U;
    end
    return r;
  endfunction

  // {carry, digit}: encodings sum to s+3, so each case is one row of the digit/carry table
  function automatic logic [3:0] add_trit(input logic [1:0] x, input logic [1:0] z, input logic [1:0] c);
    logic [2:0] e;
    e = {1'b0, x} + {1'b0, z} + {1'b0, c};
    case (e)
      3'd0:    return {T_M, T_U};
      3'd1:    return {T_M, T_A};
      3'd2:    return {T_U, T_M};
      3'd3:    return {T_U, T_U};
      3'd4:    return {T_U, T_A};
      3'd5:    return {T_A, T_M};
      default: return {T_A, T_U};
    endcase
  endfunction

  function automatic logic [VW-1:0] logic_vec(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    logic [1:0]    x, z, mn, mx, xn;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      x  = a[2*i +: 2];
      z  = b[2*i +: 2];
      mn = (x < z) ? x : z;
      mx = (x > z) ? x : z;
      xn = (x == z) ? T_A : ((x != T_U && z != T_U) ? T_M : T_U);
      // T_A - t is trit negation in this encoding
      case (op)
        3'd0:    r[2*i +: 2] = mn;
        3'd1:    r[2*i +: 2] = mx;
        3'd2:    r[2*i +: 2] = T_A - mn;
        3'd3:    r[2*i +: 2] = T_A - mx;
        3'd4:    r[2*i +: 2] = xn;
        3'd5:    r[2*i +: 2] = T_A - xn;
        default: r[2*i +: 2] = T_A - x;
      endcase
    end
    return r;
  endfunction

  assign a_n      = norm_vec(bus.a);
  assign b_n      = norm_vec(bus.b);
  assign in_ready = !rst && ((state_q == S_IDLE) || (state_q == S_DONE && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    step    = '0;
    case (state_q)
      S_ADD: begin
        step                = add_trit(a_q[2*idx_q +: 2], b_q[2*idx_q +: 2], carry_q);
        y_d[2*idx_q +: 2]   = step[1:0];
        carry_d             = step[3:2];
        idx_d               = idx_q + 1'b1;
        if (idx_q == IW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase
    // trit 0 of an ADD is summed at capture so the result lands WIDTH cycles after accept
    if (accept) begin
      if (bus.op == OP_ADD) begin
        a_d      = a_n;
        b_d      = b_n;
        step     = add_trit(a_n[1:0], b_n[1:0], T_U);
        y_d[1:0] = step[1:0];
        carry_d  = step[3:2];
        idx_d    = IW'(1);
        state_d  = (WIDTH == 1) ? S_DONE : S_ADD;
      end else begin
        y_d     = logic_vec(bus.op, a_n, b_n);
        carry_d = T_U;
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{T_U}};
      b_q     <= {WIDTH{T_U}};
      y_q     <= {WIDTH{T_U}};
      carry_q <= T_U;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_ADD);
  assign bus.y         = y_q;
  assign bus.carry     = carry_q;
endmodule

// File: tb/tb_aum_trit_alu.sv
// tb/tb_aum_trit_alu.sv - self-checking bench for aum_trit_alu against an integer balanced-ternary model
// Model works on trit values -1/0/+1 and whole-vector integers; one process compares every cycle.
module tb_aum_trit_alu;
  localparam int W  = 4;
  localparam int VW = 2 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aum_trit_alu_if #(.WIDTH(W)) bus();
  aum_trit_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [VW-1:0] y;
    logic [1:0]    c;
    int            due;
    bit            add;
  } exp_t;

  exp_t          q[$];
  logic [VW-1:0] last_y = 8'h55;
  logic [1:0]    last_c = 2'b01;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            run = 1'b0;

  function automatic int tv(input logic [1:0] t);
    return (t == 2'b00) ? -1 : ((t == 2'b10) ? 1 : 0);
  endfunction

  function automatic logic [1:0] enc(input int v);
    return (v < 0) ? 2'b00 : ((v > 0) ? 2'b10 : 2'b01);
  endfunction

  function automatic logic [VW-1:0] m_logic(input int op, input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW-1:0] r;
    int x, z, mn, mx, xn, v;
    r = '0;
    for (int i = 0; i < W; i++) begin
      x  = tv(a[2*i +: 2]);
      z  = tv(b[2*i +: 2]);
      mn = (x < z) ? x : z;
      mx = (x > z) ? x : z;
      xn = (x == 0 && z == 0) ? 1 : x * z;
      case (op)
        0: v = mn;
        1: v = mx;
        2: v = -mn;
        3: v = -mx;
        4: v = xn;
        5: v = -xn;
        default: v = -x;
      endcase
      r[2*i +: 2] = enc(v);
    end
    return r;
  endfunction

  task automatic m_add(input logic [VW-1:0] a, input logic [VW-1:0] b, output logic [VW-1:0] y, output logic [1:0] c);
    int n, p, r, d;
    n = 0;
    p = 1;
    for (int i = 0; i < W; i++) begin
      n = n + p * (tv(a[2*i +: 2]) + tv(b[2*i +: 2]));
      p = p * 3;
    end
    y = '0;
    for (int i = 0; i < W; i++) begin
      r = ((n % 3) + 3) % 3;
      d = (r == 2) ? -1 : r;
      n = (n - d) / 3;
      y[2*i +: 2] = enc(d);
    end
    c = enc(n);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model queue
  initial begin
    exp_t f;
    logic ev, eb, er, have;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (run) begin
        have = (q.size() > 0);
        ev = 1'b0;
        eb = 1'b0;
        if (have) begin
          f  = q[0];
          ev = (cyc >= f.due);
          eb = f.add && (cyc < f.due);
        end
        er = !rst && (!have || (ev && bus.out_ready));
        chk("out_valid", bus.out_valid, ev);
        chk("busy", bus.busy, eb);
        chk("in_ready", bus.in_ready, er);
        if (ev) begin
          chk("y", bus.y, f.y);
          chk("carry", bus.carry, f.c);
          if (bus.out_ready) begin
            last_y = f.y;
            last_c = f.c;
            void'(q.pop_front());
          end
        end else if (!have) begin
          chk("y_hold", bus.y, last_y);
          chk("carry_hold", bus.carry, last_c);
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b);
    bit   acc, done;
    exp_t e;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    for (int t = 0; t < 20 && !done; t++) begin
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) begin
        done = 1'b1;
        if (op == 3'd7) begin
          m_add(a, b, e.y, e.c);
          e.add = 1'b1;
          e.due = cyc + W;
        end else begin
          e.y   = m_logic(int'(op), a, b);
          e.c   = 2'b01;
          e.add = 1'b0;
          e.due = cyc + 1;
        end
        q.push_back(e);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 40 && q.size() > 0; t++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    q.delete();
    last_y = 8'h55;
    last_c = 2'b01;
    @(negedge clk);
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_y", bus.y, 8'h55);
    chk("rst_carry", bus.carry, 2'b01);
    chk("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    logic [VW-1:0] my;
    logic [1:0]    mc;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    apply_reset();
    run = 1'b1;

    chk("model_and", m_logic(0, 8'hA4, 8'h19), 8'h14);
    chk("model_xor", m_logic(5, 8'hA4, 8'h19), 8'h95);
    chk("model_xnor_rsv", m_logic(4, 8'hFF, 8'h55), 8'hAA);
    m_add(8'h56, 8'h56, my, mc);
    chk("model_add_y", my, 8'h58);
    chk("model_add_c", mc, 2'b01);
    m_add(8'hAA, 8'hAA, my, mc);
    chk("model_ovf_y", my, 8'h54);
    chk("model_ovf_c", mc, 2'b10);

    @(negedge clk);
    send(3'd0, 8'hA4, 8'h19);
    #3;
    chk("and_valid", bus.out_valid, 1);
    chk("and_y", bus.y, 8'h14);
    chk("and_carry", bus.carry, 2'b01);
    send(3'd5, 8'hA4, 8'h19);
    #3;
    chk("xor_y", bus.y, 8'h95);
    send(3'd4, 8'hFF, 8'h55);
    #3;
    chk("xnor_y", bus.y, 8'hAA);
    send(3'd1, 8'hA4, 8'h19);
    send(3'd2, 8'h1B, 8'h6C);
    send(3'd3, 8'h1B, 8'h6C);
    send(3'd6, 8'hE4, 8'h00);
    send(3'd4, 8'h24, 8'h81);
    idle();
    wait_idle();

    send(3'd7, 8'h56, 8'h56);
    idle();
    #3;
    chk("add_busy", bus.busy, 1);
    repeat (W - 1) @(negedge clk);
    #3;
    chk("add_valid", bus.out_valid, 1);
    chk("add_y", bus.y, 8'h58);
    chk("add_carry", bus.carry, 2'b01);
    wait_idle();

    send(3'd7, 8'hAA, 8'hAA);
    idle();
    repeat (W - 1) @(negedge clk);
    #3;
    chk("ovf_y", bus.y, 8'h54);
    chk("ovf_carry", bus.carry, 2'b10);
    wait_idle();

    send(3'd7, 8'h00, 8'h00);
    send(3'd7, 8'hE4, 8'h3B);
    send(3'd0, 8'h9A, 8'h66);
    send(3'd7, 8'h19, 8'h92);
    idle();
    wait_idle();

    bus.out_ready = 1'b0;
    send(3'd5, 8'hA4, 8'h19);
    idle();
    repeat (5) begin
      @(negedge clk);
      #3;
      chk("bp_y", bus.y, 8'h95);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    send(3'd6, 8'hA4, 8'h00);
    idle();
    #3;
    chk("not_y", bus.y, 8'h06);
    wait_idle();

    bus.out_ready = 1'b0;
    send(3'd7, 8'h9A, 8'h29);
    idle();
    repeat (W + 3) @(negedge clk);
    bus.out_ready = 1'b1;
    wait_idle();

    send(3'd7, 8'hAA, 8'h56);
    idle();
    @(negedge clk);
    apply_reset();
    repeat (2) @(negedge clk);

    send(3'd1, 8'h46, 8'h91);
    send(3'd7, 8'h6A, 8'h16);
    idle();
    wait_idle();

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
